// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for the shared 15-bit add/subtract datapath.
// Registers the winning operands, captures the adder result one cycle later and holds it for the owner.
module addsub_arbiter #(
    parameter int WIDTH = 15,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_sub,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_c0,
    input  logic [WIDTH-1:0] adder_s,
    input  logic             adder_v,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_v,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             owner;
    logic             prio;
    logic [WIDTH-1:0] res_s;
    logic             res_v;
    logic [CNT_W-1:0] ovf_cnt;

    // Contention resolves to the pointer; a lone valid requester always wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign accept  = |(req_valid & req_ready);
    assign acc_idx = req_ready[1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (state == IDLE) req_ready = grant;
        if (state == RESP) rsp_valid[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            owner  <= 1'b0;
            prio   <= 1'b0;
        end else if (state == IDLE && accept) begin
            op_a   <= acc_idx ? req_a1 : req_a0;
            op_b   <= acc_idx ? req_b1 : req_b0;
            op_sub <= req_sub[acc_idx];
            owner  <= acc_idx;
            prio   <= ~acc_idx;
        end
    end

    // The adder has had the whole EXEC cycle to settle on the registered operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_s   <= '0;
            res_v   <= 1'b0;
            ovf_cnt <= '0;
        end else if (state == EXEC) begin
            res_s <= adder_s;
            res_v <= adder_v;
            if (adder_v && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign adder_a   = op_a;
    assign adder_b   = op_b;
    assign adder_c0  = op_sub;
    assign rsp_s     = res_s;
    assign rsp_v     = res_v;
    assign ovf_count = ovf_cnt;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: external hybrid adder, transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_addsub_arbiter;

    localparam int W  = 15;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [W-1:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]    req_sub = '0;
    logic [W-1:0]  adder_a, adder_b, adder_s;
    logic          adder_c0, adder_v;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = '0;
    logic [W-1:0]  rsp_s;
    logic          rsp_v;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_sub(req_sub),
        .adder_a(adder_a), .adder_b(adder_b), .adder_c0(adder_c0),
        .adder_s(adder_s), .adder_v(adder_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_s(rsp_s), .rsp_v(rsp_v), .ovf_count(ovf_count)
    );

    // The external adder: B conditionally inverted by C0, V from MSB carries.
    logic [W-1:0] b_eff;
    logic [W:0]   full_sum;
    logic [W-1:0] low_sum;
    always_comb begin
        b_eff    = adder_b ^ {W{adder_c0}};
        full_sum = {1'b0, adder_a} + {1'b0, b_eff} + {{W{1'b0}}, adder_c0};
        low_sum  = {1'b0, adder_a[W-2:0]} + {1'b0, b_eff[W-2:0]} + {{(W-1){1'b0}}, adder_c0};
        adder_s  = full_sum[W-1:0];
        adder_v  = full_sum[W] ^ low_sum[W-1];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Signed integer arithmetic: result is {overflow, sum mod 2^15}.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic signed [W-1:0] sa_n, sb_n;
        int sa, sb, r;
        logic [31:0] ru;
        sa_n = a;
        sb_n = b;
        sa = sa_n;
        sb = sb_n;
        r  = sub ? sa - sb : sa + sb;
        ru = r;
        return {(r > 16383) || (r < -16384), ru[W-1:0]};
    endfunction

    // Reference model: one transaction in flight, tracked by its age since acceptance.
    bit           m_busy, m_owner, m_prio, m_sub, m_v;
    int           m_stage, m_cnt;
    logic [W-1:0] m_a, m_b, m_s;
    logic [1:0]   m_g;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_prio = 0; m_sub = 0; m_v = 0;
            m_stage = 0; m_cnt = 0; m_a = '0; m_b = '0; m_s = '0;
        end else if (!m_busy) begin
            m_g = exp_grant(req_valid, m_prio);
            if (m_g != 2'b00) begin
                m_owner = m_g[1];
                m_a     = m_owner ? req_a1 : req_a0;
                m_b     = m_owner ? req_b1 : req_b0;
                m_sub   = req_sub[m_owner];
                {m_v, m_s} = ref_op(m_a, m_b, m_sub);
                m_prio  = !m_owner;
                m_busy  = 1;
                m_stage = 0;
            end
        end else if (m_stage == 0) begin
            m_stage = 1;
            if (m_v && m_cnt < 255) m_cnt++;
        end else if (rsp_ready[m_owner]) begin
            m_busy = 0;
        end
    end

    logic [1:0] e_ready, e_rv;
    always @(negedge clk) begin
        e_ready = m_busy ? 2'b00 : exp_grant(req_valid, m_prio);
        e_rv    = (m_busy && m_stage == 1) ? (2'b01 << m_owner) : 2'b00;
        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rv);
        if (e_rv != 2'b00) begin
            check("rsp_s", rsp_s, m_s);
            check("rsp_v", rsp_v, m_v);
        end
        check("ovf_count", ovf_count, m_cnt);
        check("adder_a", adder_a, m_a);
        check("adder_b", adder_b, m_b);
        check("adder_c0", adder_c0, m_sub);
    end

    task automatic wait_ready(input int i);
        bit found = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                found = 1;
                break;
            end
        end
        check("accept_timeout", found, 1);
    endtask

    task automatic wait_rsp(input int i);
        bit got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1;
                break;
            end
        end
        check("rsp_timeout", got, 1);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        if (i == 0) begin
            req_a0 = a; req_b0 = b;
        end else begin
            req_a1 = a; req_b1 = b;
        end
        req_sub[i] = sub;
    endtask

    // Present one request, measure edges until the response, check it and complete the handshake.
    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] exp_s, input logic exp_v);
        int  edges = 0;
        bit  got = 0;
        set_req(i, a, b, sub);
        req_valid[i] = 1'b1;
        wait_ready(i);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            edges++;
            #1 req_valid[i] = 1'b0;
            @(negedge clk);
            if (rsp_valid[i]) begin
                got = 1;
                break;
            end
        end
        check("rsp_timeout", got, 1);
        check("latency_edges", edges, 2);
        check("op_rsp_s", rsp_s, exp_s);
        check("op_rsp_v", rsp_v, exp_v);
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[i] = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_ovf_count"}, ovf_count, 0);
        check({tag, "_adder_a"}, adder_a, 0);
        check({tag, "_adder_b"}, adder_b, 0);
        check({tag, "_adder_c0"}, adder_c0, 0);
        check({tag, "_rsp_v"}, rsp_v, 0);
    endtask

    int gq[$];
    int acc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        reset_checks("reset");
        check("reset_rsp_s", rsp_s, 0);
        check("reset_req_ready", req_ready, 2'b00);
        #2 rst_n = 1'b1;

        // Single requester add, then overflow add and overflow subtract
        @(posedge clk); #1;
        do_op(0, 15'h0005, 15'h0003, 1'b0, 15'h0008, 1'b0);
        check("t1_ovf_count", ovf_count, 0);
        do_op(1, 15'h3FFF, 15'h0001, 1'b0, 15'h4000, 1'b1);
        check("t2a_ovf_count", ovf_count, 1);
        do_op(1, 15'h4000, 15'h0001, 1'b1, 15'h3FFF, 1'b1);
        check("t2b_ovf_count", ovf_count, 2);

        // Both requesters valid continuously: grants alternate
        @(posedge clk); #1;
        set_req(0, 15'h0010, 15'h0011, 1'b1);
        set_req(1, 15'h0001, 15'h0001, 1'b0);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) begin
                check("rr_rsp0_s", rsp_s, 15'h7FFF);
                check("rr_rsp0_v", rsp_v, 0);
            end
            if (rsp_valid[1]) begin
                check("rr_rsp1_s", rsp_s, 15'h0002);
                check("rr_rsp1_v", rsp_v, 0);
            end
            if (|(req_valid & req_ready)) gq.push_back(int'(req_ready[1]));
        end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 rsp_ready = 2'b00;
        check("rr_grant_count", gq.size(), 4);
        for (int k = 0; k < gq.size(); k++) check("rr_grant_order", gq[k], k % 2);

        // Backpressure on requester 0 while requester 1 waits
        @(posedge clk); #1;
        set_req(0, 15'h1234, 15'h0100, 1'b0);
        req_valid = 2'b01;
        wait_ready(0);
        @(posedge clk); #1;
        set_req(1, 15'h7000, 15'h1000, 1'b1);
        req_valid = 2'b10;
        wait_rsp(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rsp_s", rsp_s, 15'h1334);
            check("bp_rsp_v", rsp_v, 0);
            check("bp_req_ready", req_ready, 2'b00);
            check("bp_rsp_valid", rsp_valid, 2'b01);
        end
        @(posedge clk); #1 rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_nonowner_ready", rsp_valid, 2'b01);
            check("bp_nonowner_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 2'b01;
        @(posedge clk); #1 rsp_ready = 2'b00;
        @(negedge clk);
        check("bp_grant_after", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(1);
        check("bp_rsp1_s", rsp_s, 15'h6000);
        check("bp_rsp1_v", rsp_v, 0);
        rsp_ready = 2'b10;
        @(posedge clk); #1 rsp_ready = 2'b00;

        // Saturation of the overflow counter
        @(posedge clk); #1;
        set_req(0, 15'h3FFF, 15'h3FFF, 1'b0);
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        acc = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            if (acc == 260) begin
                @(posedge clk);
                #1 req_valid = 2'b00;
                break;
            end
        end
        repeat (6) @(posedge clk);
        #1 rsp_ready = 2'b00;
        check("sat_ops", acc, 260);
        check("sat_ovf_count", ovf_count, 8'hFF);

        // Asynchronous reset in EXEC
        @(posedge clk); #1;
        set_req(0, 15'h4000, 15'h0001, 1'b1);
        req_valid = 2'b01;
        wait_ready(0);
        @(posedge clk); #1 req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_exec");
        @(negedge clk); #2 rst_n = 1'b1;
        req_valid = 2'b11;
        #1 check("rst_exec_prio", req_ready, 2'b01);
        req_valid = 2'b00;

        // Asynchronous reset in RESP
        @(posedge clk); #1;
        req_valid = 2'b01;
        wait_ready(0);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(0);
        check("rst_resp_pre_cnt", ovf_count, 1);
        check("rst_resp_pre_v", rsp_v, 1);
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_resp");
        @(negedge clk); #2 rst_n = 1'b1;
        req_valid = 2'b11;
        #1 check("rst_resp_prio", req_ready, 2'b01);
        req_valid = 2'b00;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
